// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: standard payload widths and bubble constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int IFID_W  = PC_W + INSTR_W;

  // NOP encodings presented in empty slots: addi x0,x0,0 for RISC-V, sll $0,$0,0 for MIPS.
  localparam logic [INSTR_W-1:0] NOP_RISCV = 32'h0000_0013;
  localparam logic [INSTR_W-1:0] NOP_MIPS  = 32'h0000_0000;

  // Number of valid entries held across two slots.
  function automatic logic [1:0] count_valid(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid bit plus DATA_W payload register with load and clear.
// Latency: 1 cycle from load to valid/q.
// Backpressure: none; the owner decides when to load or clear. Clear beats load.
// Ports: clk, rst (sync, active-high), load, clear, d -> valid, q.
module pipe_slot #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid and flush-to-bubble.
// Latency: 1 cycle from upstream transfer to dn_valid when empty; 1 payload/cycle sustained.
// Backpressure: dn_ready=0 stalls; SKID=1 registers up_ready (absorbs one stall), SKID=0 passes it through.
// Ports: clk, rst, en, flush; up_valid/up_ready/up_data; dn_valid/dn_ready/dn_data;
//        occupancy (held entries), drop_cnt (saturating count of entries discarded by flush).
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = IFID_W,
  parameter bit                SKID       = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;

  logic              up_xfer;
  logic              dn_xfer;
  logic              active;
  logic              do_flush;
  logic              m_load;
  logic              m_clear;
  logic [DATA_W-1:0] m_din;

  assign dn_valid = en & m_valid;
  assign up_xfer  = up_valid & up_ready;
  assign dn_xfer  = dn_valid & dn_ready;
  assign do_flush = en & flush;
  assign active   = en & ~flush;

  // The skid entry is always older than anything upstream, so it refills main first.
  assign m_din = s_valid ? s_data : up_data;

  generate
    if (SKID) begin : g_skid
      logic advance;
      logic s_load;
      logic s_clear;

      // Ready comes from a register only, which cuts the combinational ready chain.
      assign up_ready = en & ~s_valid;
      assign advance  = ~m_valid | dn_xfer;
      assign m_load   = active & advance & (s_valid | up_xfer);
      assign m_clear  = do_flush | (active & advance & ~s_valid & ~up_xfer);
      assign s_load   = active & m_valid & ~dn_xfer & up_xfer;
      assign s_clear  = do_flush | (active & advance & s_valid);

      pipe_slot #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (s_load),
        .clear (s_clear),
        .d     (up_data),
        .valid (s_valid),
        .q     (s_data)
      );
    end else begin : g_noskid
      assign up_ready = en & (~m_valid | dn_ready);
      assign m_load   = active & up_xfer;
      assign m_clear  = do_flush | (active & dn_xfer & ~up_xfer);
      assign s_valid  = 1'b0;
      assign s_data   = '0;
    end
  endgenerate

  pipe_slot #(.DATA_W(DATA_W)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_din),
    .valid (m_valid),
    .q     (m_data)
  );

  assign dn_data   = m_valid ? m_data : BUBBLE_VAL;
  assign occupancy = count_valid(m_valid, s_valid);

  // Drops count what was held at the flush edge, even if main also left downstream that cycle.
  logic [CNT_W:0] cnt_sum;
  assign cnt_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, occupancy};

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (do_flush) begin
      drop_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
module tb_pipe_stage_buffer;

  localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT a: SKID=1, 64-bit, RISC-V NOP bubble
  logic        en, flush, up_valid, up_ready, dn_valid, dn_ready;
  logic [63:0] up_data, dn_data;
  logic [1:0]  occupancy;
  logic [15:0] drop_cnt;

  // DUT b: SKID=0, 16-bit
  logic        b_en, b_flush, b_up_valid, b_up_ready, b_dn_valid, b_dn_ready;
  logic [15:0] b_up_data, b_dn_data;
  logic [1:0]  b_occ;
  logic [15:0] b_drop;

  // DUT c: SKID=1, CNT_W=2, 8-bit
  logic        c_en, c_flush, c_up_valid, c_up_ready, c_dn_valid, c_dn_ready;
  logic [7:0]  c_up_data, c_dn_data;
  logic [1:0]  c_occ;
  logic [1:0]  c_drop;

  pipe_stage_buffer #(.DATA_W(64), .SKID(1'b1), .BUBBLE_VAL(BUB), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  pipe_stage_buffer #(.DATA_W(16), .SKID(1'b0), .BUBBLE_VAL(16'h0000), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .flush(b_flush),
    .up_valid(b_up_valid), .up_ready(b_up_ready), .up_data(b_up_data),
    .dn_valid(b_dn_valid), .dn_ready(b_dn_ready), .dn_data(b_dn_data),
    .occupancy(b_occ), .drop_cnt(b_drop)
  );

  pipe_stage_buffer #(.DATA_W(8), .SKID(1'b1), .BUBBLE_VAL(8'h00), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .en(c_en), .flush(c_flush),
    .up_valid(c_up_valid), .up_ready(c_up_ready), .up_data(c_up_data),
    .dn_valid(c_dn_valid), .dn_ready(c_dn_ready), .dn_data(c_dn_data),
    .occupancy(c_occ), .drop_cnt(c_drop)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] qa[$];
  logic [15:0] qb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every downstream transfer must match the oldest expected payload.
  always @(negedge clk) begin
    if (!rst && dn_valid && dn_ready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_out unexpected payload got %0h expected none", dn_data);
      end else begin
        logic [63:0] e;
        e = qa.pop_front();
        if (dn_data !== e) begin
          errors++;
          $display("FAIL a_out got %0h expected %0h", dn_data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_dn_valid && b_dn_ready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_out unexpected payload got %0h expected none", b_dn_data);
      end else begin
        logic [15:0] e;
        e = qb.pop_front();
        if (b_dn_data !== e) begin
          errors++;
          $display("FAIL b_out got %0h expected %0h", b_dn_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    en = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b1;
    b_en = 1'b1; b_flush = 1'b0; b_up_valid = 1'b0; b_up_data = '0; b_dn_ready = 1'b1;
    c_en = 1'b1; c_flush = 1'b0; c_up_valid = 1'b0; c_up_data = '0; c_dn_ready = 1'b0;
    step; step;
    rst = 1'b0;
    #1;
    chk("rst_dn_valid", dn_valid, 0);
    chk("rst_dn_data", dn_data, BUB);
    chk("rst_occ", occupancy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_up_ready", up_ready, 1);
    chk("rst_b_up_ready", b_up_ready, 1);
    chk("rst_b_dn_valid", b_dn_valid, 0);

    // Stream 1..8 with dn_ready high
    for (int i = 1; i <= 8; i++) begin
      up_valid = 1'b1; up_data = 64'(i); qa.push_back(64'(i));
      #1 chk("s1_up_ready", up_ready, 1);
      step;
      chk("s1_dn_valid", dn_valid, 1);
      chk("s1_occ", occupancy, 1);
    end
    up_valid = 1'b0;
    step;
    chk("s1_drain_occ", occupancy, 0);
    chk("s1_drain_bubble", dn_data, BUB);

    // A,B,C with a 3-cycle stall
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 64'hA0; qa.push_back(64'hA0);
    step;
    up_data = 64'hB0; qa.push_back(64'hB0);
    #1 chk("s2_ready_b", up_ready, 1);
    step;
    chk("s2_occ2", occupancy, 2);
    chk("s2_ready_low", up_ready, 0);
    chk("s2_hold_a", dn_data, 64'hA0);
    up_data = 64'hC0; qa.push_back(64'hC0);
    step;
    chk("s2_occ2_hold", occupancy, 2);
    chk("s2_hold_a2", dn_data, 64'hA0);
    dn_ready = 1'b1;
    step;
    chk("s2_out_b", dn_data, 64'hB0);
    chk("s2_ready_back", up_ready, 1);
    step;
    up_valid = 1'b0;
    chk("s2_out_c", dn_data, 64'hC0);
    step;
    chk("s2_occ0", occupancy, 0);

    // Flush at occupancy 2 with X offered
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 64'h11;
    step;
    up_data = 64'h22;
    step;
    chk("s3_occ2", occupancy, 2);
    flush = 1'b1; up_data = 64'hBAD;
    step;
    flush = 1'b0; up_valid = 1'b0;
    chk("s3_dn_valid", dn_valid, 0);
    chk("s3_bubble", dn_data, BUB);
    chk("s3_occ0", occupancy, 0);
    chk("s3_drop2", drop_cnt, 2);
    // Flush at occupancy 1 while an upstream transfer is offered and ready
    up_valid = 1'b1; up_data = 64'h33;
    step;
    flush = 1'b1; up_data = 64'hBAD2;
    #1 chk("s3_ready_in_flush", up_ready, 1);
    step;
    flush = 1'b0; up_valid = 1'b0;
    chk("s3b_occ0", occupancy, 0);
    chk("s3b_drop3", drop_cnt, 3);
    dn_ready = 1'b1;
    step; step;

    // en low for 4 cycles mid-stream, with a flush attempt while disabled
    up_valid = 1'b1; up_data = 64'hE1; qa.push_back(64'hE1);
    step;
    en = 1'b0; up_data = 64'hE2;
    #1;
    chk("s4_up_ready", up_ready, 0);
    chk("s4_dn_valid", dn_valid, 0);
    for (int k = 0; k < 4; k++) begin
      flush = (k == 2);
      step;
      chk("s4_occ", occupancy, 1);
      chk("s4_drop", drop_cnt, 3);
      chk("s4_dn_valid_hold", dn_valid, 0);
    end
    flush = 1'b0; en = 1'b1; qa.push_back(64'hE2);
    step;
    up_valid = 1'b0;
    step;
    chk("s4_occ0", occupancy, 0);

    // SKID=0 pass-through
    for (int i = 1; i <= 5; i++) begin
      b_up_valid = 1'b1; b_up_data = 16'h100 + 16'(i); qb.push_back(16'h100 + 16'(i));
      #1 chk("b_up_ready", b_up_ready, 1);
      step;
      chk("b_dn_valid", b_dn_valid, 1);
      chk("b_occ", b_occ, 1);
    end
    b_up_data = 16'h106; b_dn_ready = 1'b0;
    #1 chk("b_ready_stall", b_up_ready, 0);
    step;
    chk("b_hold", b_dn_data, 16'h105);
    b_dn_ready = 1'b1;
    #1 chk("b_ready_comb", b_up_ready, 1);
    qb.push_back(16'h106);
    step;
    b_up_valid = 1'b0;
    step;
    chk("b_occ0", b_occ, 0);

    // Saturating drop counter, CNT_W=2
    c_up_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      c_up_data = 8'(2 * r + 1);
      step;
      c_up_data = 8'(2 * r + 2);
      step;
      chk("c_occ2", c_occ, 2);
      c_flush = 1'b1;
      step;
      c_flush = 1'b0;
      chk("c_drop", c_drop, (r == 0) ? 64'd2 : 64'd3);
      chk("c_occ0", c_occ, 0);
    end
    c_up_valid = 1'b0;
    step;

    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
